instruction_loader: RTL and testbench

- Writer-side companion to the byte-addressed, big-endian instruction memory.
- Accepts a burst of 32-bit instruction words over a valid/ready stream.
- Serialises each word into four byte writes on the memory's byte write port, most significant byte at the lowest address.
- Sits between the host/boot source and the instruction memory write port, so a program image can be loaded at run time instead of through file initialisation.

---
 rtl/instruction_loader.sv | 145 ++++++++++++++
 tb/tb_instruction_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Streams 32-bit instruction words into a byte-wide, big-endian instruction memory
// write port, one byte per cycle, starting at BASE_ADDR.
module instruction_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-2:0] length_i,
    input  logic [31:0]           in_word_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic                  write_enable_o,
    output logic [ADDR_WIDTH-1:0] write_address_o,
    output logic [7:0]            write_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_e;

    // Two extra bits so BASE_ADDR + 4*Length can never wrap during the overflow check.
    localparam int CW = ADDR_WIDTH + 2;
    localparam logic [CW-1:0]         BASE_EXT = CW'(BASE_ADDR);
    localparam logic [CW-1:0]         MEM_SIZE = CW'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-2:0] rem_q;
    logic [31:0]           word_q;
    logic [1:0]            idx_q;

    logic [CW-1:0]         req_end;
    logic                  overflow;
    logic [1:0]            idx_d;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Overflow test, next byte index and the combinational ready.
    always_comb begin
        req_end    = BASE_EXT + (CW'(length_i) << 2);
        overflow   = (req_end > MEM_SIZE);
        idx_d      = idx_q + 2'd1;
        in_ready_o = (state_q == ACCEPT);
    end

    // Session FSM with registered write-port and status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            word_q          <= 32'h0;
            idx_q           <= 2'd0;
            write_enable_o  <= 1'b0;
            write_address_o <= '0;
            write_data_o    <= 8'h00;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            error_o         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    write_enable_o <= 1'b0;
                    done_o         <= 1'b0;
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (overflow) begin
                            error_o <= 1'b1;
                            done_o  <= 1'b1;
                            state_q <= DONE;
                        end else if (length_i == '0) begin
                            error_o <= 1'b0;
                            done_o  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            error_o <= 1'b0;
                            addr_q  <= BASE_A;
                            rem_q   <= length_i;
                            state_q <= ACCEPT;
                        end
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (in_valid_i) begin
                        word_q          <= in_word_i;
                        idx_q           <= 2'd0;
                        write_enable_o  <= 1'b1;
                        write_address_o <= addr_q;
                        write_data_o    <= byte_sel(in_word_i, 2'd0);
                        state_q         <= WRITE;
                    end else begin
                        write_enable_o <= 1'b0;
                    end
                end
                WRITE: begin
                    if (idx_q == 2'd3) begin
                        write_enable_o <= 1'b0;
                        addr_q         <= addr_q + ADDR_WIDTH'(4);
                        rem_q          <= rem_q - (ADDR_WIDTH-1)'(1);
                        if (rem_q == (ADDR_WIDTH-1)'(1)) begin
                            done_o  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= ACCEPT;
                        end
                    end else begin
                        idx_q           <= idx_d;
                        write_enable_o  <= 1'b1;
                        write_address_o <= addr_q + ADDR_WIDTH'(idx_d);
                        write_data_o    <= byte_sel(word_q, idx_d);
                    end
                end
                DONE: begin
                    write_enable_o <= 1'b0;
                    done_o         <= 1'b0;
                    busy_o         <= 1'b0;
                    state_q        <= IDLE;
                end
                default: begin
                    write_enable_o <= 1'b0;
                    done_o         <= 1'b0;
                    busy_o         <= 1'b0;
                    state_q        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed, table-driven bench for instruction_loader (ADDR_WIDTH=10, BASE_ADDR=4).
module tb_instruction_loader;

    localparam int AW   = 10;
    localparam int BASE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-2:0] length;
    logic [31:0]   in_word;
    logic          in_valid;
    logic          in_ready_o;
    logic          write_enable_o;
    logic [AW-1:0] write_address_o;
    logic [7:0]    write_data_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    instruction_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .length_i        (length),
        .in_word_i       (in_word),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready_o),
        .write_enable_o  (write_enable_o),
        .write_address_o (write_address_o),
        .write_data_o    (write_data_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          viol = 0;
    logic [9:0]  wlog_a [$];
    logic [7:0]  wlog_d [$];
    int          wlog_t [$];
    logic [7:0]  mem [1024];
    logic [31:0] tx_words [256];

    typedef struct {
        int               len;
        int               gap;
        bit               poke;
        bit               exp_err;
        logic [2:0][31:0] words;
    } vec_t;
    vec_t tbl [6];

    // Write/done monitor and memory model, sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (write_enable_o) begin
            wlog_a.push_back(write_address_o);
            wlog_d.push_back(write_data_o);
            wlog_t.push_back(cyc);
            mem[write_address_o] <= write_data_o;
        end
        if (done_o) done_cnt <= done_cnt + 1;
        if (in_ready_o && (write_enable_o || !busy_o)) viol <= viol + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        int b;
        in_valid = 1'b1;
        in_word  = w;
        b = 0;
        while (!in_ready_o && b < 50) begin
            step();
            b++;
        end
        if (b >= 50) check("ready_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_session(input int len, input int gap, input bit poke, input bit exp_err);
        int lb, db, nsend, b;
        lb    = wlog_a.size();
        db    = done_cnt;
        nsend = exp_err ? 0 : len;
        start  = 1'b1;
        length = len[AW-2:0];
        step();
        start = 1'b0;
        for (int w = 0; w < nsend; w++) begin
            for (int g = 0; g < gap; g++) begin
                start  = poke;
                length = 9'd5;
                step();
                start = 1'b0;
            end
            send_word(tx_words[w]);
        end
        b = 0;
        while (done_cnt == db && b < 40) begin
            step();
            b++;
        end
        step();
        step();
        check("done_pulses", done_cnt - db, 32'd1);
        check("error", {31'd0, error_o}, {31'd0, exp_err});
        check("busy_end", {31'd0, busy_o}, 32'd0);
        check("write_count", wlog_a.size() - lb, 4 * nsend);
        for (int i = 0; i < 4 * nsend && lb + i < wlog_a.size(); i++) begin
            if (wlog_a[lb+i] !== 10'(BASE + i) || wlog_d[lb+i] !== 8'(tx_words[i/4] >> (24 - 8 * (i % 4)))) begin
                check("byte_write", {12'd0, wlog_a[lb+i], 2'b00, wlog_d[lb+i]},
                      {12'd0, 10'(BASE + i), 2'b00, 8'(tx_words[i/4] >> (24 - 8 * (i % 4)))});
            end
            if (i % 4 != 0) begin
                if (wlog_t[lb+i] != wlog_t[lb+i-1] + 1) check("byte_consecutive", wlog_t[lb+i], wlog_t[lb+i-1] + 1);
            end
        end
    endtask

    initial begin
        int lb;
        tbl[0] = '{1,   0, 1'b0, 1'b0, {32'h0, 32'h0, 32'hDEADBEEF}};
        tbl[1] = '{3,   2, 1'b0, 1'b0, {32'hAC0A0004, 32'h01095020, 32'h20080005}};
        tbl[2] = '{256, 0, 1'b0, 1'b1, {32'h0, 32'h0, 32'h0}};
        tbl[3] = '{1,   0, 1'b0, 1'b0, {32'h0, 32'h0, 32'hCAFEF00D}};
        tbl[4] = '{2,   6, 1'b1, 1'b0, {32'h0, 32'h89ABCDEF, 32'h01234567}};
        tbl[5] = '{255, 0, 1'b0, 1'b0, {32'h0, 32'h0, 32'h0}};

        rst = 1'b1; start = 1'b0; length = '0; in_word = 32'h0; in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        check("rst_we", {31'd0, write_enable_o}, 32'd0);
        check("rst_addr", {22'd0, write_address_o}, 32'd0);
        check("rst_data", {24'd0, write_data_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_error", {31'd0, error_o}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 256; i++)
                tx_words[i] = (i < 3) ? tbl[v].words[i] : ((i * 32'h01010101) ^ 32'hA5000000);
            run_session(tbl[v].len, tbl[v].gap, tbl[v].poke, tbl[v].exp_err);
            if (v == 0) check("mem_read", {mem[4], mem[5], mem[6], mem[7]}, 32'hDEADBEEF);
            if (v == 5) check("mem_top", {mem[1020], mem[1021], mem[1022], mem[1023]}, tx_words[254]);
        end

        // Overflow sets Error; an empty session then clears it with a lone Done pulse.
        run_session(300, 0, 1'b0, 1'b1);
        lb = wlog_a.size();
        start = 1'b1; length = 9'd0;
        step();
        start = 1'b0;
        check("len0_done", {31'd0, done_o}, 32'd1);
        check("len0_busy", {31'd0, busy_o}, 32'd1);
        check("len0_error", {31'd0, error_o}, 32'd0);
        step();
        check("len0_done_drop", {31'd0, done_o}, 32'd0);
        check("len0_idle", {31'd0, busy_o}, 32'd0);
        check("len0_writes", wlog_a.size() - lb, 32'd0);

        // Reset after the second byte of a word.
        lb = wlog_a.size();
        start = 1'b1; length = 9'd1;
        step();
        start = 1'b0;
        send_word(32'h11223344);
        check("pre_rst_we", {31'd0, write_enable_o}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_we", {31'd0, write_enable_o}, 32'd0);
        check("mid_rst_addr", {22'd0, write_address_o}, 32'd0);
        check("mid_rst_data", {24'd0, write_data_o}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready_o}, 32'd0);
        check("mid_rst_writes", wlog_a.size() - lb, 32'd2);
        if (wlog_a.size() >= lb + 2)
            check("mid_rst_byte1", {wlog_a[lb+1], wlog_d[lb+1]}, {10'd5, 8'h22});
        repeat (3) step();
        check("mid_rst_quiet", wlog_a.size() - lb, 32'd2);

        check("ready_only_in_accept", viol, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
